oled_msg_streamer: RTL

// - Parametrised message sequencer feeding the OLED controller's byte-write port.
// - Holds a loadable character buffer and streams 0..DEPTH bytes on start.
// - Respects downstream backpressure (buffer_full), inserts optional inter-byte gaps, supports repeat mode.
// - Replaces hard-coded per-character state sequences in top-level demo wrappers.

---
 rtl/oled_msg_streamer_if.sv | 29 ++
 rtl/oled_msg_streamer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/oled_msg_streamer_if.sv
// Load, start/abort control and downstream byte-write signals of the OLED message streamer.
interface oled_msg_streamer_if #(
   parameter int DATA_W = 8,
   parameter int AW     = 4
);
   logic              ld_we;
   logic [AW-1:0]     ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [AW:0]       msg_len;
   logic              start;
   logic              repeat_en;
   logic              abort;
   logic              out_full;
   logic [DATA_W-1:0] out_data;
   logic              out_we;
   logic              busy;
   logic              done;
   logic [AW-1:0]     char_idx;

   modport master (
      output ld_we, ld_addr, ld_data, msg_len, start, repeat_en, abort, out_full,
      input  out_data, out_we, busy, done, char_idx
   );

   modport slave (
      input  ld_we, ld_addr, ld_data, msg_len, start, repeat_en, abort, out_full,
      output out_data, out_we, busy, done, char_idx
   );
endinterface

// File: rtl/oled_msg_streamer.sv
// Streams a loadable character buffer to the OLED byte-write port with backpressure, gaps and repeat.
// Optional CR/LF trailer after each pass when OLED_STREAM_CRLF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; buffer loads allowed
// SEND   | presenting buf[char_idx]; transfers when !out_full
// GAP    | idle cycles after an accepted byte, then resume at ret_q
// CR, LF | trailer bytes 0D, 0A (OLED_STREAM_CRLF_EN only)
// WRAP   | end of pass; restart on repeat, else finish
// FIN    | done pulse, back to IDLE
module oled_msg_streamer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = $clog2(DEPTH),
   parameter int GAP_CYCLES = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   oled_msg_streamer_if.slave bus
);
`ifdef OLED_STREAM_CRLF_EN
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WRAP, S_FIN, S_CR, S_LF} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WRAP, S_FIN} state_t;
`endif

   localparam int            GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [GW-1:0] GAP_ONE = GW'(1);
   localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
   localparam logic [AW:0]   ONE_L   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   state_t            ret_q, ret_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [AW:0]       len_q, len_d;
   logic              rpt_q, rpt_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       len_min;
   logic              last;
   logic              sending;
   logic [DATA_W-1:0] out_data_c;
   state_t            empty_tgt;
   state_t            rep_tgt;

   assign len_min = (bus.msg_len > DEPTH_L) ? DEPTH_L : bus.msg_len;
   assign last    = ({1'b0, idx_q} == (len_q - ONE_L));

`ifdef OLED_STREAM_CRLF_EN
   assign empty_tgt = S_CR;
   assign rep_tgt   = (len_q == '0) ? S_CR : S_SEND;
   assign sending   = (state_q == S_SEND) || (state_q == S_CR) || (state_q == S_LF);
`else
   assign empty_tgt = S_FIN;
   assign rep_tgt   = S_SEND;
   assign sending   = (state_q == S_SEND);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ret_q   <= S_SEND;
         idx_q   <= '0;
         len_q   <= '0;
         rpt_q   <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         rpt_q   <= rpt_d;
         gap_q   <= gap_d;
      end
   end

   // Buffer is deliberately left out of reset so a message survives a controller reset.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && bus.ld_we)
         mem_q[bus.ld_addr] <= bus.ld_data;
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      idx_d   = idx_q;
      len_d   = len_q;
      rpt_d   = rpt_q;
      gap_d   = gap_q;
      if (state_q != S_IDLE && bus.abort) begin
         state_d = S_IDLE;
         idx_d   = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  len_d   = len_min;
                  rpt_d   = bus.repeat_en;
                  idx_d   = '0;
                  state_d = (len_min == '0) ? empty_tgt : S_SEND;
               end
            end
            S_SEND: begin
               if (!bus.out_full) begin
                  if (last) begin
`ifdef OLED_STREAM_CRLF_EN
                     if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LD;
                        ret_d   = S_CR;
                     end else begin
                        state_d = S_CR;
                     end
`else
                     state_d = S_WRAP;
`endif
                  end else if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LD;
                     ret_d   = S_SEND;
                  end else begin
                     idx_d = idx_q + ONE_A;
                  end
               end
            end
            // Leaving toward SEND advances the index; from the last byte it wraps to 0.
            S_GAP: begin
               if (gap_q == '0) begin
                  state_d = ret_q;
                  if (ret_q == S_SEND)
                     idx_d = last ? '0 : idx_q + ONE_A;
               end else begin
                  gap_d = gap_q - GAP_ONE;
               end
            end
`ifdef OLED_STREAM_CRLF_EN
            S_CR: begin
               if (!bus.out_full) begin
                  if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LD;
                     ret_d   = S_LF;
                  end else begin
                     state_d = S_LF;
                  end
               end
            end
            S_LF: begin
               if (!bus.out_full)
                  state_d = S_WRAP;
            end
`endif
            S_WRAP: begin
               if (rpt_q) begin
                  if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LD;
                     ret_d   = rep_tgt;
                  end else begin
                     state_d = rep_tgt;
                     idx_d   = '0;
                  end
               end else begin
                  state_d = S_FIN;
               end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      out_data_c = '0;
      case (state_q)
         S_SEND: out_data_c = mem_q[idx_q];
`ifdef OLED_STREAM_CRLF_EN
         S_CR:   out_data_c = DATA_W'(8'h0D);
         S_LF:   out_data_c = DATA_W'(8'h0A);
`endif
         default: out_data_c = '0;
      endcase
   end

   assign bus.out_data = out_data_c;
   assign bus.out_we   = sending && !bus.out_full;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_FIN);
   assign bus.char_idx = idx_q;
endmodule
